// File: rtl/id_hazard_stage.sv
// Decode stage: register file, operand forwarding, load-use stall FSM and ID/EX register.
// Define ID_WB_BYPASS_EN to forward the write-back port into ID instead of stalling on it.
module id_hazard_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CTRL_W   = 16,
    localparam int unsigned AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              if_valid,
    input  logic [AW-1:0]     if_rs,
    input  logic [AW-1:0]     if_rt,
    input  logic [AW-1:0]     if_rd,
    input  logic [CTRL_W-1:0] if_ctrl,
    input  logic              if_mem_read,
    input  logic              if_reg_write,
    input  logic [XLEN-1:0]   if_imm,
    input  logic [XLEN-1:0]   if_pc4,
    input  logic              exm_we,
    input  logic [AW-1:0]     exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_rs_data,
    output logic [XLEN-1:0]   ex_rt_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc4
);

    localparam int RF_DEPTH = 1 << AW;

    typedef enum logic {
        StRun,
        StStall
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc4;
    } idex_t;

    // ------------------------------------------------------------------
    // Register file (entry 0 is never written; reads of it are forced to zero)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [RF_DEPTH];
    logic            rf_we;

    assign rf_we = wb_we && (wb_addr != '0) && (32'(wb_addr) < NREG);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    function automatic logic [XLEN-1:0] select_operand(input logic [AW-1:0] addr);
        logic [XLEN-1:0] result;
        if (addr == '0) begin
            result = '0;
        end else if (exm_we && (exm_rd == addr)) begin
            result = exm_data;
`ifdef ID_WB_BYPASS_EN
        end else if (wb_we && (wb_addr == addr)) begin
            result = wb_data;
`endif
        end else begin
            result = rf_q[addr];
        end
        return result;
    endfunction

    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;

    assign rs_data = select_operand(if_rs);
    assign rt_data = select_operand(if_rt);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic load_hz;
    logic wb_hz;

    assign load_hz = if_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == if_rs) || (ex_rd == if_rt));

`ifdef ID_WB_BYPASS_EN
    assign wb_hz = 1'b0;
`else
    // Without the bypass, an in-flight register write that EX/MEM does not cover
    // would be read stale, so ID waits one cycle for the register file to update.
    function automatic logic wb_conflict(input logic [AW-1:0] addr);
        return wb_we && (wb_addr != '0) && (wb_addr == addr) &&
               !(exm_we && (exm_rd == addr));
    endfunction

    assign wb_hz = if_valid && (wb_conflict(if_rs) || wb_conflict(if_rt));
`endif

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       stall;
    logic       issue;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        issue   = 1'b0;
        if (flush) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (load_hz) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            cnt_d   = 2'(LOAD_LAT - 1);
                        end
                    end else if (wb_hz) begin
                        stall = 1'b1;
                    end else begin
                        issue = if_valid;
                    end
                end
                StStall: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Input-only hazards must not leak out while reset is held.
    assign id_stall = reset_b & stall;

    // ------------------------------------------------------------------
    // ID/EX register: loads the decoded instruction or a zeroed bubble
    // ------------------------------------------------------------------
    idex_t idex_d, idex_q;

    always_comb begin
        idex_d = '0;
        if (issue) begin
            idex_d.valid     = 1'b1;
            idex_d.mem_read  = if_mem_read;
            idex_d.reg_write = if_reg_write;
            idex_d.rs        = if_rs;
            idex_d.rt        = if_rt;
            idex_d.rd        = if_rd;
            idex_d.ctrl      = if_ctrl;
            idex_d.rs_data   = rs_data;
            idex_d.rt_data   = rt_data;
            idex_d.imm       = if_imm;
            idex_d.pc4       = if_pc4;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid     = idex_q.valid;
    assign ex_mem_read  = idex_q.mem_read;
    assign ex_reg_write = idex_q.reg_write;
    assign ex_rs        = idex_q.rs;
    assign ex_rt        = idex_q.rt;
    assign ex_rd        = idex_q.rd;
    assign ex_ctrl      = idex_q.ctrl;
    assign ex_rs_data   = idex_q.rs_data;
    assign ex_rt_data   = idex_q.rt_data;
    assign ex_imm       = idex_q.imm;
    assign ex_pc4       = idex_q.pc4;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage (LOAD_LAT=3): directed vector table, hand-written stall/flush/reset
// sequences, and randomized traffic against a cycle-level reference model.
module tb_id_hazard_stage;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int LOAD_LAT = 3;
    localparam int CTRL_W   = 16;
    localparam int AW       = 5;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_b;
    logic              if_valid, if_mem_read, if_reg_write;
    logic [AW-1:0]     if_rs, if_rt, if_rd;
    logic [CTRL_W-1:0] if_ctrl;
    logic [XLEN-1:0]   if_imm, if_pc4;
    logic              exm_we, wb_we, flush;
    logic [AW-1:0]     exm_rd, wb_addr;
    logic [XLEN-1:0]   exm_data, wb_data;
    logic              id_stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [AW-1:0]     ex_rs, ex_rt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_rs_data, ex_rt_data, ex_imm, ex_pc4;

    id_hazard_stage #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .LOAD_LAT(LOAD_LAT),
        .CTRL_W  (CTRL_W)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .if_valid    (if_valid),
        .if_rs       (if_rs),
        .if_rt       (if_rt),
        .if_rd       (if_rd),
        .if_ctrl     (if_ctrl),
        .if_mem_read (if_mem_read),
        .if_reg_write(if_reg_write),
        .if_imm      (if_imm),
        .if_pc4      (if_pc4),
        .exm_we      (exm_we),
        .exm_rd      (exm_rd),
        .exm_data    (exm_data),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .id_stall    (id_stall),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_ctrl     (ex_ctrl),
        .ex_rs_data  (ex_rs_data),
        .ex_rt_data  (ex_rt_data),
        .ex_imm      (ex_imm),
        .ex_pc4      (ex_pc4)
    );

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc4;
        logic              exm_we;
        logic [AW-1:0]     exm_rd;
        logic [XLEN-1:0]   exm_data;
        logic              wb_we;
        logic [AW-1:0]     wb_addr;
        logic [XLEN-1:0]   wb_data;
        logic              flush;
    } in_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc4;
    } ex_t;

    typedef struct packed {
        in_t             in;
        logic            stall;
        logic            valid;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: architectural registers, expected ID/EX contents and
    // the number of further stall cycles still owed to an earlier load-use hazard.
    logic [XLEN-1:0] rf_m [NREG];
    ex_t             ex_m;
    int              stall_left;

    function automatic in_t mk(input bit v, input int rs, input int rt, input int rd,
                               input bit xwe, input int xrd, input logic [31:0] xdata,
                               input bit wwe, input int waddr, input logic [31:0] wdata);
        in_t r = '0;
        r.valid     = v;
        r.reg_write = 1'b1;
        r.rs        = AW'(rs);
        r.rt        = AW'(rt);
        r.rd        = AW'(rd);
        r.ctrl      = 16'hC000 | 16'(rd);
        r.imm       = 32'h0000_0100 + 32'(rd);
        r.pc4       = 32'h0000_4000 + 32'(rd * 4);
        r.exm_we    = xwe;
        r.exm_rd    = AW'(xrd);
        r.exm_data  = xdata;
        r.wb_we     = wwe;
        r.wb_addr   = AW'(waddr);
        r.wb_data   = wdata;
        return r;
    endfunction

    function automatic ex_t issued(input in_t v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        ex_t e;
        e.valid     = 1'b1;
        e.mem_read  = v.mem_read;
        e.reg_write = v.reg_write;
        e.rs        = v.rs;
        e.rt        = v.rt;
        e.rd        = v.rd;
        e.ctrl      = v.ctrl;
        e.rs_data   = a;
        e.rt_data   = b;
        e.imm       = v.imm;
        e.pc4       = v.pc4;
        return e;
    endfunction

    function automatic ex_t dut_ex();
        ex_t e;
        e.valid     = ex_valid;
        e.mem_read  = ex_mem_read;
        e.reg_write = ex_reg_write;
        e.rs        = ex_rs;
        e.rt        = ex_rt;
        e.rd        = ex_rd;
        e.ctrl      = ex_ctrl;
        e.rs_data   = ex_rs_data;
        e.rt_data   = ex_rt_data;
        e.imm       = ex_imm;
        e.pc4       = ex_pc4;
        return e;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_ex(input string name, input ex_t exp);
        ex_t act;
        act = dut_ex();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        if_valid     = v.valid;
        if_mem_read  = v.mem_read;
        if_reg_write = v.reg_write;
        if_rs        = v.rs;
        if_rt        = v.rt;
        if_rd        = v.rd;
        if_ctrl      = v.ctrl;
        if_imm       = v.imm;
        if_pc4       = v.pc4;
        exm_we       = v.exm_we;
        exm_rd       = v.exm_rd;
        exm_data     = v.exm_data;
        wb_we        = v.wb_we;
        wb_addr      = v.wb_addr;
        wb_data      = v.wb_data;
        flush        = v.flush;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic drive(input in_t v, input bit exp_stall, input string tag);
        apply(v);
        #2;
        check_bit({tag, ".id_stall"}, id_stall, exp_stall);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] model_operand(input in_t v, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (v.exm_we && v.exm_rd == a) return v.exm_data;
        if (BYPASS && v.wb_we && v.wb_addr == a) return v.wb_data;
        return rf_m[a];
    endfunction

    function automatic bit model_wb_clash(input in_t v, input logic [AW-1:0] a);
        return v.wb_we && v.wb_addr != 0 && v.wb_addr == a && !(v.exm_we && v.exm_rd == a);
    endfunction

    task automatic model_step(input in_t v, output bit stall);
        ex_t nx;
        bit  ld, wbc;
        nx    = '0;
        stall = 1'b0;
        ld  = v.valid && ex_m.valid && ex_m.mem_read && ex_m.rd != 0 &&
              (ex_m.rd == v.rs || ex_m.rd == v.rt);
        wbc = !BYPASS && v.valid && (model_wb_clash(v, v.rs) || model_wb_clash(v, v.rt));
        if (v.flush) begin
            stall_left = 0;
        end else if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
        end else if (ld) begin
            stall      = 1'b1;
            stall_left = LOAD_LAT - 1;
        end else if (wbc) begin
            stall = 1'b1;
        end else if (v.valid) begin
            nx = issued(v, model_operand(v, v.rs), model_operand(v, v.rt));
        end
        if (v.wb_we && v.wb_addr != 0) rf_m[v.wb_addr] = v.wb_data;
        ex_m = nx;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) rf_m[i] = '0;
        ex_m       = '0;
        stall_left = 0;
    endtask

    task automatic run_cycle(input in_t v, input string tag);
        bit s;
        apply(v);
        #2;
        model_step(v, s);
        check_bit({tag, ".id_stall"}, id_stall, s);
        @(posedge clk);
        #1;
        check_ex({tag, ".ex"}, ex_m);
    endtask

    task automatic do_reset(input string tag);
        apply('0);
        reset_b = 1'b0;
        #1;
        check_bit({tag, ".id_stall"}, id_stall, 1'b0);
        check_ex({tag, ".ex"}, '0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        model_reset();
    endtask

    vec_t tbl [12];
    in_t  lw, add, v;

    initial begin
        // Reset held with inputs that would otherwise request a write-back stall.
        reset_b = 1'b0;
        apply(mk(1, 7, 0, 3, 0, 0, 0, 1, 7, 32'h55));
        #3;
        check_bit("reset.id_stall", id_stall, 1'b0);
        check_ex("reset.ex", '0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        apply('0);

        tbl[0]  = '{mk(1, 0, 0, 3, 1, 0, 32'hFFFF_FFFF, 0, 0, 0), 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[1]  = '{mk(1, 4, 0, 3, 1, 4, 32'hDEAD_BEEF, 1, 4, 32'h1234), 1'b0, 1'b1,
                    32'hDEAD_BEEF, 32'h0};
        tbl[2]  = '{mk(1, 4, 4, 8, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h1234, 32'h1234};
        tbl[3]  = '{mk(1, 1, 2, 3, 0, 0, 0, 1, 9, 32'h99), 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[4]  = '{mk(1, 9, 4, 3, 1, 9, 32'hAAAA_AAAA, 0, 0, 0), 1'b0, 1'b1,
                    32'hAAAA_AAAA, 32'h1234};
`ifdef ID_WB_BYPASS_EN
        tbl[5]  = '{mk(1, 7, 0, 2, 0, 0, 0, 1, 7, 32'h55), 1'b0, 1'b1, 32'h55, 32'h0};
`else
        tbl[5]  = '{mk(1, 7, 0, 2, 0, 0, 0, 1, 7, 32'h55), 1'b1, 1'b0, 32'h0, 32'h0};
`endif
        tbl[6]  = '{mk(1, 7, 0, 2, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h55, 32'h0};
        tbl[7]  = '{mk(0, 4, 4, 3, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[8]  = '{mk(1, 4, 0, 3, 0, 4, 32'h0BAD, 0, 0, 0), 1'b0, 1'b1, 32'h1234, 32'h0};
        tbl[9]  = '{mk(1, 0, 9, 3, 0, 0, 0, 1, 0, 32'hFF), 1'b0, 1'b1, 32'h0, 32'h99};
        tbl[10] = '{mk(1, 9, 7, 3, 1, 9, 32'h42, 1, 9, 32'h77), 1'b0, 1'b1, 32'h42, 32'h55};
        tbl[11] = '{mk(1, 9, 0, 3, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 32'h77, 32'h0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in, tbl[i].stall, $sformatf("vec%0d", i));
            check_ex($sformatf("vec%0d.ex", i),
                     tbl[i].valid ? issued(tbl[i].in, tbl[i].rs_data, tbl[i].rt_data) : '0);
        end

        // Load-use: lw r5 in EX, add r6,r5,r1 waits exactly LOAD_LAT cycles.
        lw          = mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        lw.mem_read = 1'b1;
        add         = mk(1, 5, 1, 6, 0, 0, 0, 0, 0, 0);
        drive(lw, 1'b0, "lu.lw");
        check_bit("lu.lw.ex_mem_read", ex_mem_read, 1'b1);
        for (int i = 0; i < LOAD_LAT; i++) begin
            drive(add, 1'b1, $sformatf("lu.stall%0d", i));
            check_ex($sformatf("lu.bubble%0d", i), '0);
        end
        drive(add, 1'b0, "lu.issue");
        check_ex("lu.add.ex", issued(add, 32'h0, 32'h0));

        // Flush in the second stall cycle aborts the stall.
        drive(lw, 1'b0, "fl.lw");
        drive(add, 1'b1, "fl.stall0");
        v       = add;
        v.flush = 1'b1;
        drive(v, 1'b0, "fl.flush");
        check_ex("fl.bubble", '0);
        drive(add, 1'b0, "fl.after");
        check_ex("fl.add.ex", issued(add, 32'h0, 32'h0));

        // Randomized traffic against the model.
        do_reset("rst1");
        for (int n = 0; n < 400; n++) begin
            v           = '0;
            v.valid     = ($urandom_range(3) != 0);
            v.mem_read  = ($urandom_range(2) == 0);
            v.reg_write = $urandom_range(1) != 0;
            v.rs        = AW'($urandom_range(7));
            v.rt        = AW'($urandom_range(7));
            v.rd        = AW'($urandom_range(7));
            v.ctrl      = CTRL_W'($urandom);
            v.imm       = $urandom;
            v.pc4       = $urandom;
            v.exm_we    = $urandom_range(1) != 0;
            v.exm_rd    = AW'($urandom_range(7));
            v.exm_data  = $urandom;
            v.wb_we     = $urandom_range(1) != 0;
            v.wb_addr   = AW'($urandom_range(7));
            v.wb_data   = $urandom;
            v.flush     = ($urandom_range(15) == 0);
            run_cycle(v, $sformatf("rnd%0d", n));
        end
        do_reset("rst2");

        // Reset in the middle of a stall; register file must also be cleared.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5555), 1'b0, "mr.wr5");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1111), 1'b0, "mr.wr1");
        drive(lw, 1'b0, "mr.lw");
        check_ex("mr.lw.ex", issued(lw, 32'h1111, 32'h0));
        drive(add, 1'b1, "mr.stall0");
        reset_b = 1'b0;
        #1;
        check_bit("mr.reset.id_stall", id_stall, 1'b0);
        check_ex("mr.reset.ex", '0);
        @(posedge clk);
        #1;
        check_bit("mr.held.id_stall", id_stall, 1'b0);
        reset_b = 1'b1;
        drive(add, 1'b0, "mr.first");
        check_ex("mr.first.ex", issued(add, 32'h0, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_hazard_stage.md
ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 Parameter XLEN, default 32: operand/immediate/PC datapath width.
REQ-002 Parameter NREG, default 32: register count; address width AW = clog2(NREG); register 0 reads as zero.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..4: load-use stall length in cycles.
REQ-004 Parameter CTRL_W, default 16: width of the opaque control bundle carried to EX.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset_b  in  1  reset, asynchronous, active-low.
REQ-007 if_valid  in  1  instruction in IF/ID is valid.
REQ-008 if_rs, if_rt, if_rd  in  AW each  source/destination register numbers.
REQ-009 if_ctrl  in  CTRL_W  decoded control bundle; if_mem_read, if_reg_write  in  1 each.
REQ-010 if_imm, if_pc4  in  XLEN each  extended immediate, PC+4.
REQ-011 exm_we  in  1; exm_rd  in  AW; exm_data  in  XLEN  EX/MEM forwarding source.
REQ-012 wb_we  in  1; wb_addr  in  AW; wb_data  in  XLEN  register-file write port.
REQ-013 flush  in  1  squash instruction in ID.
REQ-014 id_stall  out  1  hold PC and IF/ID this cycle.
REQ-015 ex_valid, ex_mem_read, ex_reg_write  out  1 each; ex_rs, ex_rt, ex_rd  out  AW; ex_ctrl  out  CTRL_W; ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  XLEN  registered ID/EX fields.

Function
REQ-016 Register file: NREG x XLEN, written at rising edge when wb_we and wb_addr != 0; asynchronous read.
REQ-017 Operand select per source, priority: addr 0 -> 0; exm_we and exm_rd match -> exm_data; wb_we and wb_addr match -> wb_data (see REQ-030); else register file.
REQ-018 Load-use hazard (hz) = if_valid & ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == if_rs | ex_rd == if_rt).
REQ-019 FSM states RUN, STALL; 2-bit down-counter cnt.
REQ-020 RUN, no hz: id_stall=0; ID/EX loads all if_* fields and selected operands; ex_valid <= if_valid.
REQ-021 RUN, hz: id_stall=1; ID/EX loads bubble; if LOAD_LAT>1 -> STALL with cnt=LOAD_LAT-1, else remain RUN.
REQ-022 STALL: id_stall=1; ID/EX loads bubble; cnt decrements; cnt==1 -> RUN. Total stall = exactly LOAD_LAT cycles per hazard.
REQ-023 Bubble: ex_valid, ex_mem_read, ex_reg_write, ex_ctrl = 0; other ID/EX fields = 0.
REQ-024 if_valid=0 in RUN: ID/EX loads bubble, id_stall=0.
REQ-025 flush has highest priority: id_stall=0 combinationally, ID/EX loads bubble, FSM -> RUN, cnt=0, any in-progress stall aborted.
REQ-026 Same-cycle wb write and ID read of the same register: ID sees wb_data via REQ-017 (with REQ-030 enabled).
REQ-027 Latency: ID/EX outputs valid one cycle after the accepting edge.

Reset
REQ-028 reset_b low: all ID/EX outputs 0, FSM=RUN, cnt=0, id_stall=0 (combinational), all registers 0; takes effect immediately, mid-stall included.
REQ-029 After reset_b rises, first edge behaves as RUN with empty ID/EX.

Configuration
REQ-030 Macro ID_WB_BYPASS_EN: defined -> wb_data bypass path per REQ-017; undefined -> no wb bypass, and a RUN-state match (wb_we, wb_addr != 0, equals if_rs or if_rt, no exm match) asserts id_stall for one cycle with a bubble, no FSM state change.

Verification
REQ-031 Reset: reset_b=0 mid-STALL (LOAD_LAT=3) -> all outputs 0, id_stall=0 immediately; first post-reset edge RUN.
REQ-032 LOAD_LAT=3: ID/EX holds lw r5; IF has add r6,r5,r1 -> id_stall=1 for exactly 3 cycles, 3 bubbles, then add issues.
REQ-033 exm_we=1, exm_rd=4, exm_data=0xDEAD_BEEF and wb writes r4=0x1234 same cycle; ID reads r4 -> ex_rs_data=0xDEADBEEF.
REQ-034 Read r0 with exm_rd=0, exm_we=1, exm_data=0xFFFF_FFFF -> ex_rs_data=0.
REQ-035 flush=1 in second stall cycle (LOAD_LAT=3) -> id_stall=0 that cycle, bubble in ID/EX, next cycle RUN.
REQ-036 wb_we=1, wb_addr=7, wb_data=0x55; ID reads r7 -> with ID_WB_BYPASS_EN ex_rs_data=0x55 next edge; without, one stall cycle then 0x55.
